branch_resolve_ctrl: RTL and testbench

//  Sequences conditional-branch resolution in the EX stage of the 5-stage MIPS pipeline.
//  - Accepts a decoded branch and its operands; stalls the front end while operands are pending.
//  - Evaluates beq/bne/bltz/bgtz/blez/bgez, then redirects the PC and flushes younger stages.
//  - Keeps saturating branch statistics. Sits between ID/EX control and the PC-select mux.

---
 rtl/branch_resolve_ctrl.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// EX-stage conditional branch resolution: operand-wait stall, condition evaluation,
// PC redirect with front-end flush, and saturating branch statistics.
module branch_resolve_ctrl #(
  parameter int unsigned DATA_BITS    = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 br_valid,
  input  logic [2:0]           br_op,
  input  logic                 operand_ready,
  input  logic [DATA_BITS-1:0] rs_val,
  input  logic [DATA_BITS-1:0] rt_val,
  input  logic [DATA_BITS-1:0] br_target,
  output logic                 br_accept,
  output logic                 stall_front,
  output logic                 pc_sel,
  output logic [DATA_BITS-1:0] pc_target,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 hazard_timeout,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     br_total,
  output logic [CNT_W-1:0]     br_taken
);

  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned FLUSH_W    = 3;
  localparam int unsigned LAST_FLUSH = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic                accept_c;
  logic                stall_c;
  logic                taken_c;
  logic                illegal_c;
  logic                rs_neg;
  logic                rs_zero;

  // Branch condition on a signed rs, evaluated every cycle against the held operands
  always_comb begin
    rs_neg    = rs_val[DATA_BITS-1];
    rs_zero   = (rs_val == '0);
    illegal_c = 1'b0;
    taken_c   = 1'b0;
    case (br_op)
      3'd1:    taken_c = (rs_val == rt_val);
      3'd2:    taken_c = (rs_val != rt_val);
      3'd3:    taken_c = rs_neg;
      3'd4:    taken_c = !rs_neg && !rs_zero;
      3'd5:    taken_c = rs_neg || rs_zero;
      3'd6:    taken_c = !rs_neg;
      default: illegal_c = 1'b1;
    endcase
  end

  // Next-state and combinational handshake outputs
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    stall_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (br_valid) begin
          if (operand_ready) begin
            accept_c = 1'b1;
            if (taken_c) state_nxt = ST_REDIRECT;
          end else begin
            stall_c   = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (br_valid && operand_ready) begin
          accept_c  = 1'b1;
          state_nxt = taken_c ? ST_REDIRECT : ST_IDLE;
        end
      end
      ST_REDIRECT: state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: begin
        if (flush_cnt >= FLUSH_W'(LAST_FLUSH)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign br_accept   = accept_c;
  assign stall_front = stall_c;

  // State, redirect/flush outputs, wait/flush counters, statistics and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pc_sel         <= 1'b0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      pc_target      <= '0;
      wait_cnt       <= '0;
      flush_cnt      <= '0;
      hazard_timeout <= 1'b0;
      illegal_op     <= 1'b0;
      br_total       <= '0;
      br_taken       <= '0;
    end else begin
      state      <= state_nxt;
      pc_sel     <= (state_nxt == ST_REDIRECT);
      flush_ifid <= (state_nxt == ST_REDIRECT) || (state_nxt == ST_FLUSH);
      flush_idex <= (state_nxt == ST_REDIRECT) || (state_nxt == ST_FLUSH);

      if (state == ST_IDLE && br_valid && !operand_ready) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WAIT_W'(MAX_WAIT - 1)) hazard_timeout <= 1'b1;
      end

      if (state == ST_REDIRECT) flush_cnt <= '0;
      else if (state == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;

      if (accept_c) begin
        pc_target <= br_target;
        if (br_total != '1) br_total <= br_total + 1'b1;
        if (taken_c && br_taken != '1) br_taken <= br_taken + 1'b1;
        if (illegal_c) illegal_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized bench for branch_resolve_ctrl against a transaction-level model of
// branch outcome, stall/flush timeline, saturating counters and sticky flags.
module tb_branch_resolve_ctrl;

  localparam int DATA_BITS    = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int MAX_WAIT     = 15;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 br_valid;
  logic [2:0]           br_op;
  logic                 operand_ready;
  logic [DATA_BITS-1:0] rs_val;
  logic [DATA_BITS-1:0] rt_val;
  logic [DATA_BITS-1:0] br_target;
  logic                 br_accept;
  logic                 stall_front;
  logic                 pc_sel;
  logic [DATA_BITS-1:0] pc_target;
  logic                 flush_ifid;
  logic                 flush_idex;
  logic                 hazard_timeout;
  logic                 illegal_op;
  logic [CNT_W-1:0]     br_total;
  logic [CNT_W-1:0]     br_taken;

  int checks   = 0;
  int failures = 0;

  int m_total;
  int m_taken;
  bit m_hazard;
  bit m_illegal;

  branch_resolve_ctrl #(
    .DATA_BITS(DATA_BITS), .FLUSH_CYCLES(FLUSH_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op),
    .operand_ready(operand_ready), .rs_val(rs_val), .rt_val(rt_val), .br_target(br_target),
    .br_accept(br_accept), .stall_front(stall_front), .pc_sel(pc_sel), .pc_target(pc_target),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .hazard_timeout(hazard_timeout),
    .illegal_op(illegal_op), .br_total(br_total), .br_taken(br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int signed s;
    s = int'(rs);
    case (op)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return s < 0;
      3'd4:    return s > 0;
      3'd5:    return s <= 0;
      3'd6:    return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'($urandom_range(0, 3));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic model_reset();
    m_total   = 0;
    m_taken   = 0;
    m_hazard  = 1'b0;
    m_illegal = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_total"}, 64'(br_total), 64'(m_total));
    chk({tag, "_taken"}, 64'(br_taken), 64'(m_taken));
    chk({tag, "_illegal"}, 64'(illegal_op), 64'(m_illegal));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      br_valid      = 1'b0;
      operand_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_accept", 64'(br_accept), 64'(0));
      chk("idle_stall", 64'(stall_front), 64'(0));
      chk("idle_pcsel", 64'(pc_sel), 64'(0));
      chk("idle_flush", 64'({flush_ifid, flush_idex}), 64'(0));
    end
  endtask

  // One branch from IDLE: w cycles of missing operands, then accept, then redirect/flush if taken
  task automatic do_branch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] tgt, input int w, input bit abort_in_flush);
    bit tk;
    tk = exp_taken(op, rs, rt);
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1;
      br_valid = 1'b1; br_op = op; rs_val = rs; rt_val = rt; br_target = tgt;
      operand_ready = (k == w);
      @(negedge clk);
      if (k == 0) check_stats("pre");
      chk("accept", 64'(br_accept), 64'(k == w));
      chk("stall", 64'(stall_front), 64'(w > 0));
      chk("wait_pcsel", 64'(pc_sel), 64'(0));
      chk("wait_flush", 64'({flush_ifid, flush_idex}), 64'(0));
      chk("hazard", 64'(hazard_timeout), 64'(m_hazard || (k >= 1 && k - 1 >= MAX_WAIT)));
    end
    if (m_total < CNT_MAX) m_total++;
    if (tk && m_taken < CNT_MAX) m_taken++;
    if (op == 3'd0 || op == 3'd7) m_illegal = 1'b1;
    if (w >= MAX_WAIT) m_hazard = 1'b1;
    if (tk) begin
      for (int f = 0; f < FLUSH_CYCLES; f++) begin
        @(posedge clk); #1;
        br_valid = 1'($urandom_range(0, 1)); operand_ready = 1'($urandom_range(0, 1));
        br_op = 3'($urandom_range(1, 6)); rs_val = rnd_val(); rt_val = rs_val;
        @(negedge clk);
        chk("redir_accept", 64'(br_accept), 64'(0));
        chk("redir_stall", 64'(stall_front), 64'(0));
        chk("redir_pcsel", 64'(pc_sel), 64'(f == 0));
        chk("redir_flush", 64'({flush_ifid, flush_idex}), 64'(2'b11));
        if (f == 0) chk("redir_target", 64'(pc_target), 64'(tgt));
        if (abort_in_flush && f == 1) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_flush", 64'({flush_ifid, flush_idex}), 64'(0));
          chk("rst_pcsel", 64'(pc_sel), 64'(0));
          chk("rst_target", 64'(pc_target), 64'(0));
          chk("rst_total", 64'(br_total), 64'(0));
          model_reset();
          return;
        end
      end
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          w;

    rst_n = 1'b0; br_valid = 1'b0; br_op = 3'd0; operand_ready = 1'b0;
    rs_val = '0; rt_val = '0; br_target = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pcsel", 64'(pc_sel), 64'(0));
    chk("reset_flush", 64'({flush_ifid, flush_idex}), 64'(0));
    chk("reset_target", 64'(pc_target), 64'(0));
    chk("reset_hazard", 64'(hazard_timeout), 64'(0));
    check_stats("reset");
    rst_n = 1'b1;

    do_branch(3'd1, 32'd5, 32'd5, 32'h0000_1000, 0, 1'b0);
    do_branch(3'd2, 32'd7, 32'd7, 32'h0000_2000, 0, 1'b0);
    do_branch(3'd3, 32'h8000_0000, 32'd0, 32'h0000_3000, 0, 1'b0);
    do_branch(3'd6, 32'd0, 32'd9, 32'h0000_4000, 0, 1'b0);
    do_branch(3'd4, 32'd0, 32'd0, 32'h0000_5000, 0, 1'b0);
    do_branch(3'd5, 32'h7FFF_FFFF, 32'd0, 32'h0000_6000, 0, 1'b0);
    do_branch(3'd2, 32'd1, 32'd2, 32'h0000_7000, 3, 1'b0);
    do_branch(3'd1, 32'd3, 32'd4, 32'h0000_8000, 20, 1'b0);
    do_branch(3'd7, 32'd0, 32'd0, 32'h0000_9000, 0, 1'b0);
    idle(1);
    check_stats("directed");
    chk("directed_hazard", 64'(hazard_timeout), 64'(m_hazard));

    // Reset asserted in the middle of a flush, then a fresh branch from IDLE
    do_branch(3'd1, 32'd9, 32'd9, 32'h0000_A000, 0, 1'b1);
    br_valid = 1'b0;
    @(negedge clk);
    chk("rst_hazard", 64'(hazard_timeout), 64'(0));
    check_stats("in_reset");
    rst_n = 1'b1;
    do_branch(3'd2, 32'd1, 32'd0, 32'h0000_B000, 1, 1'b0);

    for (int i = 0; i < 500; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = rnd_val();
      rt = ($urandom_range(0, 1) == 1) ? rs : rnd_val();
      w  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 3));
      do_branch(op, rs, rt, 32'($urandom()), w, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // Drive both counters to saturation
    for (int i = 0; i < 300; i++) do_branch(3'd1, 32'd1, 32'd1, 32'($urandom()), 0, 1'b0);
    idle(1);
    check_stats("sat");
    chk("sat_total_max", 64'(br_total), 64'(CNT_MAX));
    chk("sat_taken_max", 64'(br_taken), 64'(CNT_MAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
